// File: rtl/uart_tx_engine.sv
// uart_tx_engine: parametrised UART transmitter (start, data LSB first, optional parity, 1/2 stop bits).
// Define UART_TX_BREAK_EN to add the break_req port and the BREAK state.
module uart_tx_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  ready,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    input  logic [DIV_W-1:0]      baud_div,
`ifdef UART_TX_BREAK_EN
    input  logic                  break_req,
`endif
    output logic                  tx_out,
    output logic                  busy
);
    localparam int IW = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
`ifdef UART_TX_BREAK_EN
        BRK,
`endif
        STOP
    } state_t;

    state_t                state, state_n;
    logic [DIV_W-1:0]      cnt, cnt_n, div_l;
    logic [IW-1:0]         idx, idx_n;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_l, stop2_l, par_bit;
    logic                  wrap, accept, brk_go, line;

    assign wrap = cnt == div_l;
`ifdef UART_TX_BREAK_EN
    assign brk_go = state == IDLE && ready && break_req;
`else
    assign brk_go = 1'b0;
`endif
    assign accept = state == IDLE && ready && data_valid && !brk_go;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = (state == IDLE || wrap) ? '0 : cnt + 1'b1;
        line    = 1'b1;
        case (state)
            IDLE: begin
                if (accept) state_n = START;
`ifdef UART_TX_BREAK_EN
                if (brk_go) state_n = BRK;
`endif
            end
            START: begin
                line = 1'b0;
                if (wrap) state_n = DATA;
            end
            DATA: begin
                line = shreg[0];
                if (wrap) begin
                    idx_n = idx + 1'b1;
                    if (idx == IW'(DATA_WIDTH - 1)) begin
                        idx_n   = '0;
                        state_n = par_en_l ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                line = par_bit;
                if (wrap) state_n = STOP;
            end
            STOP: begin
                if (wrap) begin
                    idx_n = idx + 1'b1;
                    if (idx == IW'(stop2_l)) begin
                        idx_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BRK: begin
                line = 1'b0;
                if (wrap) begin
                    idx_n = idx + 1'b1;
                    if (idx == IW'(DATA_WIDTH + 2)) begin
                        idx_n   = '0;
                        state_n = break_req ? BRK : IDLE;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Line, busy and ready trail the state by one edge so nothing reaches tx_out combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            div_l    <= '0;
            shreg    <= '0;
            par_en_l <= 1'b0;
            stop2_l  <= 1'b0;
            par_bit  <= 1'b0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            ready    <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            tx_out <= line;
            busy   <= state != IDLE;
            ready  <= state == IDLE && !accept && !brk_go;
            if (accept || brk_go) div_l <= baud_div;
            if (accept) begin
                shreg    <= data_in;
                par_en_l <= par_en;
                stop2_l  <= stop2;
                par_bit  <= ^data_in ^ par_typ;
            end else if (state == DATA && wrap) begin
                shreg <= shreg >> 1;
            end
        end
    end
endmodule
